// File: rtl/rpn_eval_ctrl.sv
// Reverse-Polish evaluator control stage: takes operand/operator tokens, drives the
// downstream LIFO's push/pop strobes, and pushes binary-op results back onto it.
module rpn_eval_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       tok_valid,
    output logic                       tok_ready,
    input  logic                       tok_is_op,
    input  logic [WIDTH-1:0]           tok_data,
    output logic                       stk_push,
    output logic                       stk_pop,
    output logic [WIDTH-1:0]           stk_din,
    input  logic [WIDTH-1:0]           stk_dout,
    output logic                       res_valid,
    output logic [WIDTH-1:0]           res_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    input  logic                       err_clr,
    output logic                       err_ovf,
    output logic                       err_unf
);

    localparam int LW = $clog2(DEPTH+1);

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP_B,
        WAIT_B,
        POP_A,
        WAIT_A,
        PUSH_R
    } state_t;

    state_t           state_q, state_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [1:0]       op_q, op_d;
    logic             push_q, push_d;
    logic             pop_q, pop_d;
    logic             rv_q, rv_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             accept;
    logic             set_ovf;
    logic             set_unf;
    logic [WIDTH-1:0] alu;

    assign tok_ready = rstN && (state_q == IDLE);
    assign accept    = tok_valid && tok_ready;

    // stk_dout holds the deeper operand 'a' during WAIT_A; b was captured in WAIT_B.
    always_comb begin
        case (op_q)
            2'b00:   alu = stk_dout + b_q;
            2'b01:   alu = stk_dout - b_q;
            2'b10:   alu = stk_dout & b_q;
            default: alu = stk_dout | b_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        din_d   = din_q;
        res_d   = res_q;
        op_d    = op_q;
        push_d  = 1'b0;
        pop_d   = 1'b0;
        rv_d    = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;

        // level follows the stack itself: it moves on the edge that ends a strobe cycle
        level_d = level_q;
        if (push_q) begin
            level_d = level_q + LW'(1);
        end else if (pop_q) begin
            level_d = level_q - LW'(1);
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!tok_is_op) begin
                        if (level_q < LW'(DEPTH)) begin
                            state_d = PUSH;
                            push_d  = 1'b1;
                            din_d   = tok_data;
                        end else begin
                            set_ovf = 1'b1;
                        end
                    end else begin
                        if (level_q < LW'(2)) begin
                            set_unf = 1'b1;
                        end else begin
                            state_d = POP_B;
                            pop_d   = 1'b1;
                            op_d    = tok_data[1:0];
                        end
                    end
                end
            end
            PUSH:   state_d = IDLE;
            POP_B:  state_d = WAIT_B;
            WAIT_B: begin
                b_d     = stk_dout;
                state_d = POP_A;
                pop_d   = 1'b1;
            end
            POP_A:  state_d = WAIT_A;
            WAIT_A: begin
                state_d = PUSH_R;
                push_d  = 1'b1;
                din_d   = alu;
                res_d   = alu;
                rv_d    = 1'b1;
            end
            PUSH_R: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ovf_d = set_ovf | (ovf_q & ~err_clr);
        unf_d = set_unf | (unf_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q <= IDLE;
            level_q <= '0;
            b_q     <= '0;
            din_q   <= '0;
            res_q   <= '0;
            op_q    <= '0;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            rv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            b_q     <= b_d;
            din_q   <= din_d;
            res_q   <= res_d;
            op_q    <= op_d;
            push_q  <= push_d;
            pop_q   <= pop_d;
            rv_q    <= rv_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign stk_push  = push_q;
    assign stk_pop   = pop_q;
    assign stk_din   = din_q;
    assign res_valid = rv_q;
    assign res_data  = res_q;
    assign level     = level_q;
    assign err_ovf   = ovf_q;
    assign err_unf   = unf_q;

endmodule

// File: tb/tb_rpn_eval_ctrl.sv
// Bench for rpn_eval_ctrl: a behavioural LIFO answers the stack strobes, and a
// queue-based RPN evaluator predicts results, levels and error flags.
module tb_rpn_eval_ctrl;

    localparam int W  = 4;
    localparam int D  = 8;
    localparam int LW = $clog2(D+1);

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          tok_valid = 1'b0;
    logic          tok_is_op = 1'b0;
    logic [W-1:0]  tok_data = '0;
    logic          err_clr = 1'b0;
    logic          tok_ready;
    logic          stk_push;
    logic          stk_pop;
    logic [W-1:0]  stk_din;
    logic [W-1:0]  stk_dout;
    logic          res_valid;
    logic [W-1:0]  res_data;
    logic [LW-1:0] level;
    logic          err_ovf;
    logic          err_unf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rpn_eval_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok_is_op (tok_is_op),
        .tok_data  (tok_data),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_din   (stk_din),
        .stk_dout  (stk_dout),
        .res_valid (res_valid),
        .res_data  (res_data),
        .level     (level),
        .err_clr   (err_clr),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf)
    );

    // Downstream LIFO: dout registered on the pop cycle's closing edge
    logic [W-1:0] mem [D];
    int sp = 0;
    always @(posedge clk) begin
        if (!rstN) begin
            sp       <= 0;
            stk_dout <= '0;
        end else if (stk_pop) begin
            if (sp > 0) begin
                stk_dout <= mem[sp-1];
                sp       <= sp - 1;
            end
        end else if (stk_push) begin
            if (sp < D) begin
                mem[sp] <= stk_din;
                sp      <= sp + 1;
            end
        end
    end

    int n_push = 0, n_pop = 0, n_rv = 0, n_viol = 0;
    always @(negedge clk) begin
        if (stk_push) n_push <= n_push + 1;
        if (stk_pop) n_pop <= n_pop + 1;
        if (res_valid) n_rv <= n_rv + 1;
        if ((stk_push && stk_pop) || (stk_pop && sp == 0) || (stk_push && sp == D))
            n_viol <= n_viol + 1;
    end

    // Reference RPN evaluator
    logic [W-1:0] q_stk[$];
    logic [W-1:0] m_res = '0;
    logic         m_ovf = 1'b0, m_unf = 1'b0;
    int           m_push = 0, m_pop = 0, m_rv = 0;

    function automatic void model_reset();
        q_stk.delete();
        m_res = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    // Returns the number of cycles tok_ready should stay low after the accept
    function automatic int model_tok(input logic op, input logic [W-1:0] d);
        logic [W-1:0] a, b, r;
        if (!op) begin
            if (q_stk.size() < D) begin
                q_stk.push_back(d);
                m_push++;
                return 1;
            end
            m_ovf = 1'b1;
            return 0;
        end
        if (q_stk.size() < 2) begin
            m_unf = 1'b1;
            return 0;
        end
        b = q_stk.pop_back();
        a = q_stk.pop_back();
        case (d[1:0])
            2'd0:    r = a + b;
            2'd1:    r = a - b;
            2'd2:    r = a & b;
            default: r = a | b;
        endcase
        q_stk.push_back(r);
        m_res = r;
        m_push++;
        m_pop += 2;
        m_rv++;
        return 5;
    endfunction

    task automatic send(input logic op, input logic [W-1:0] d);
        int unsigned n = 0;
        @(negedge clk);
        tok_valid = 1'b1;
        tok_is_op = op;
        tok_data  = d;
        while (!tok_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!tok_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: tok_ready=%b want 1", tok_ready);
            tok_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (err_clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        void'(model_tok(op, d));
        #1;
        tok_valid = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic settle();
        int unsigned n = 0;
        @(negedge clk);
        while (!tok_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!tok_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: tok_ready=%b want 1", tok_ready);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstN      = 1'b0;
        tok_valid = 1'b0;
        err_clr   = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstN      = 1'b0;
        tok_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (tok_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 0", tok_ready);
        end
        n_cmp++;
        if ({stk_push, stk_pop, stk_din, res_valid, res_data, err_ovf, err_unf, level} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got push=%b pop=%b din=%h rv=%b res=%h ovf=%b unf=%b lvl=%0d want all 0",
                     stk_push, stk_pop, stk_din, res_valid, res_data, err_ovf, err_unf, level);
        end
        tok_valid = 1'b0;
        rstN      = 1'b1;
        model_reset();
        @(negedge clk);
        n_cmp++;
        if (tok_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b want 1", tok_ready);
        end
    endtask

    task automatic test_sub();
        int p0, r0;
        do_reset();
        p0 = n_pop;
        r0 = n_rv;
        send(1'b0, 4'h3); settle();
        send(1'b0, 4'h5); settle();
        send(1'b1, 4'h1); settle();
        n_cmp++;
        if ({n_pop - p0, n_rv - r0} !== {32'd2, 32'd1}) begin
            n_err++;
            $display("FAIL sub_strobes: got pops=%0d rv=%0d want pops=2 rv=1", n_pop - p0, n_rv - r0);
        end
        n_cmp++;
        if ({res_data, level} !== {4'hE, LW'(1)}) begin
            n_err++;
            $display("FAIL sub_result: got res=%h lvl=%0d want res=e lvl=1", res_data, level);
        end
    endtask

    task automatic test_wrap_unf();
        int p0;
        do_reset();
        send(1'b0, 4'h9); settle();
        send(1'b0, 4'h9); settle();
        send(1'b1, 4'h0); settle();
        n_cmp++;
        if ({res_data, level} !== {4'h2, LW'(1)}) begin
            n_err++;
            $display("FAIL add_wrap: got res=%h lvl=%0d want res=2 lvl=1", res_data, level);
        end
        p0 = n_pop;
        send(1'b1, 4'h0); settle();
        n_cmp++;
        if ({err_unf, err_ovf, level, res_data} !== {1'b1, 1'b0, LW'(1), 4'h2} || n_pop != p0) begin
            n_err++;
            $display("FAIL underflow: got unf=%b ovf=%b lvl=%0d res=%h pops=%0d want unf=1 ovf=0 lvl=1 res=2 pops=0",
                     err_unf, err_ovf, level, res_data, n_pop - p0);
        end
    endtask

    task automatic test_ovf();
        int pu0;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            send(1'b0, W'(i)); settle();
        end
        n_cmp++;
        if (level !== LW'(8)) begin
            n_err++;
            $display("FAIL fill_level: got %0d want 8", level);
        end
        pu0 = n_push;
        err_clr = 1'b1;
        send(1'b0, 4'hF); settle();
        n_cmp++;
        if ({err_ovf, level} !== {1'b1, LW'(8)} || n_push != pu0) begin
            n_err++;
            $display("FAIL overflow_setwins: got ovf=%b lvl=%0d pushes=%0d want ovf=1 lvl=8 pushes=0",
                     err_ovf, level, n_push - pu0);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        n_cmp++;
        if ({err_ovf, err_unf} !== {m_ovf, m_unf}) begin
            n_err++;
            $display("FAIL err_clear: got ovf=%b unf=%b want 0 0", err_ovf, err_unf);
        end
    endtask

    task automatic test_logic();
        do_reset();
        send(1'b0, 4'hC); settle();
        send(1'b0, 4'hA); settle();
        send(1'b1, 4'h2); settle();
        n_cmp++;
        if (res_data !== 4'h8) begin
            n_err++;
            $display("FAIL and_op: got %h want 8", res_data);
        end
        send(1'b0, 4'h1); settle();
        send(1'b1, 4'h3); settle();
        n_cmp++;
        if ({res_data, level} !== {4'h9, LW'(1)}) begin
            n_err++;
            $display("FAIL or_op: got res=%h lvl=%0d want res=9 lvl=1", res_data, level);
        end
    endtask

    task automatic test_back_to_back();
        logic         tk_op [16];
        logic [W-1:0] tk_d  [16];
        int idx = 0, low = 0, exp_low = 0, cyc = 0;
        int pu0, po0, rv0, mpu0, mpo0, mrv0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            tk_op[i] = (i >= 2) && ($urandom_range(2) == 0);
            tk_d[i]  = W'($urandom);
        end
        pu0 = n_push; po0 = n_pop; rv0 = n_rv;
        mpu0 = m_push; mpo0 = m_pop; mrv0 = m_rv;
        @(negedge clk);
        tok_valid = 1'b1;
        tok_is_op = tk_op[0];
        tok_data  = tk_d[0];
        while (cyc < 300) begin
            cyc++;
            if (tok_ready) begin
                if (idx > 0) begin
                    n_cmp++;
                    if (low != exp_low) begin
                        n_err++;
                        $display("FAIL b2b_ready_low tok%0d: got %0d cycles want %0d", idx - 1, low, exp_low);
                    end
                end
                if (idx == 16) break;
                @(posedge clk);
                exp_low = model_tok(tk_op[idx], tk_d[idx]);
                idx++;
                low = 0;
                @(negedge clk);
                if (idx < 16) begin
                    tok_is_op = tk_op[idx];
                    tok_data  = tk_d[idx];
                end else begin
                    tok_valid = 1'b0;
                end
            end else begin
                low++;
                @(negedge clk);
            end
        end
        tok_valid = 1'b0;
        n_cmp++;
        if (idx != 16 || cyc >= 300) begin
            n_err++;
            $display("FAIL b2b_timeout: got %0d tokens want 16", idx);
        end
        n_cmp++;
        if ({n_push - pu0, n_pop - po0, n_rv - rv0} !== {m_push - mpu0, m_pop - mpo0, m_rv - mrv0}) begin
            n_err++;
            $display("FAIL b2b_counts: got push=%0d pop=%0d rv=%0d want push=%0d pop=%0d rv=%0d",
                     n_push - pu0, n_pop - po0, n_rv - rv0, m_push - mpu0, m_pop - mpo0, m_rv - mrv0);
        end
        n_cmp++;
        if ({level, res_data, err_ovf, err_unf} !== {LW'(q_stk.size()), m_res, m_ovf, m_unf}) begin
            n_err++;
            $display("FAIL b2b_state: got lvl=%0d res=%h ovf=%b unf=%b want lvl=%0d res=%h ovf=%b unf=%b",
                     level, res_data, err_ovf, err_unf, q_stk.size(), m_res, m_ovf, m_unf);
        end
    endtask

    task automatic test_reset_mid();
        int rv0;
        do_reset();
        send(1'b0, 4'h7); settle();
        send(1'b0, 4'h3); settle();
        rv0 = n_rv;
        send(1'b1, 4'h0);
        repeat (4) @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({tok_ready, stk_push, stk_pop, stk_din, res_valid, res_data, err_ovf, err_unf, level} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: got rdy=%b push=%b pop=%b din=%h rv=%b res=%h ovf=%b unf=%b lvl=%0d want all 0",
                     tok_ready, stk_push, stk_pop, stk_din, res_valid, res_data, err_ovf, err_unf, level);
        end
        rstN = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (n_rv != rv0) begin
            n_err++;
            $display("FAIL midreset_no_result: got %0d res_valid pulses want 0", n_rv - rv0);
        end
        send(1'b0, 4'h2); settle();
        send(1'b0, 4'h2); settle();
        send(1'b1, 4'h0); settle();
        n_cmp++;
        if ({res_data, level} !== {4'h4, LW'(1)}) begin
            n_err++;
            $display("FAIL midreset_recover: got res=%h lvl=%0d want res=4 lvl=1", res_data, level);
        end
    endtask

    task automatic test_random();
        int pu0, po0, rv0, mpu0, mpo0, mrv0;
        logic         op;
        logic [W-1:0] d;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(7) == 0) begin
                @(negedge clk);
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            op = ($urandom_range(99) < 45);
            d  = W'($urandom);
            pu0 = n_push; po0 = n_pop; rv0 = n_rv;
            mpu0 = m_push; mpo0 = m_pop; mrv0 = m_rv;
            send(op, d);
            settle();
            n_cmp++;
            if ({level, res_data, err_ovf, err_unf} !== {LW'(q_stk.size()), m_res, m_ovf, m_unf}) begin
                n_err++;
                $display("FAIL rand_state tok%0d op=%b d=%h: got lvl=%0d res=%h ovf=%b unf=%b want lvl=%0d res=%h ovf=%b unf=%b",
                         i, op, d, level, res_data, err_ovf, err_unf, q_stk.size(), m_res, m_ovf, m_unf);
            end
            n_cmp++;
            if ({n_push - pu0, n_pop - po0, n_rv - rv0} !== {m_push - mpu0, m_pop - mpo0, m_rv - mrv0}) begin
                n_err++;
                $display("FAIL rand_counts tok%0d: got push=%0d pop=%0d rv=%0d want push=%0d pop=%0d rv=%0d",
                         i, n_push - pu0, n_pop - po0, n_rv - rv0, m_push - mpu0, m_pop - mpo0, m_rv - mrv0);
            end
        end
    endtask

    task automatic test_protocol();
        n_cmp++;
        if (n_viol != 0) begin
            n_err++;
            $display("FAIL strobe_protocol: got %0d illegal strobe cycles want 0", n_viol);
        end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_wrap_unf();
        test_ovf();
        test_logic();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
